// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches 16-bit words over req/ack, decodes them and
// issues one ALU/LDI op at a time over valid/ready. NOP, JMP and HLT are consumed here.
module instr_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        issue_op,
  output logic [2:0]        issue_reg_dst,
  output logic [2:0]        issue_reg_src,
  output logic [7:0]        issue_imm,
  output logic              halted,
  output logic              illegal
);

  if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
    $error("instr_fetch_decode: ADDR_W must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_LDI = 4'h7,
    OP_JMP = 4'h8,
    OP_HLT = 4'hF
  } opcode_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [3:0]          op_q, op_d;
  logic [2:0]          dst_q, dst_d;
  logic [2:0]          src_q, src_d;
  logic [7:0]          imm_q, imm_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  logic                fetch_fire;
  opcode_e             fetch_op;

  // req_q is only ever high in FETCH, so it doubles as the ack qualifier:
  // an ack arriving while no request is outstanding never reaches the decoder.
  assign fetch_fire = req_q && imem_ack;
  assign fetch_op   = opcode_e'(imem_rdata[15:12]);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statements can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_d     = src_q;
    imm_d     = imm_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_FETCH: begin
        if (fetch_fire) begin
          unique case (fetch_op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              op_d    = imem_rdata[15:12];
              dst_d   = imem_rdata[11:9];
              src_d   = imem_rdata[8:6];
              imm_d   = 8'h00;
              state_d = S_ISSUE;
            end
            OP_LDI: begin
              op_d    = imem_rdata[15:12];
              dst_d   = imem_rdata[11:9];
              src_d   = 3'd0;
              imm_d   = imem_rdata[7:0];
              state_d = S_ISSUE;
            end
            OP_NOP: pc_d = pc_q + ADDR_W'(1);
            OP_JMP: pc_d = imem_rdata[ADDR_W-1:0];
            OP_HLT: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: begin
              halted_d  = 1'b1;
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end
      end

      S_ISSUE: begin
        if (issue_ready) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_HALT;
    endcase

    // Handshake outputs are registered copies of the next state, which keeps
    // imem_ack and issue_ready off every combinational path to an output.
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_ISSUE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      op_q      <= 4'h0;
      dst_q     <= 3'd0;
      src_q     <= 3'd0;
      imm_q     <= 8'h00;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign issue_valid   = valid_q;
  assign issue_op      = op_q;
  assign issue_reg_dst = dst_q;
  assign issue_reg_src = src_q;
  assign issue_imm     = imm_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: a memory responder serves fetches,
// a monitor checks fetch addresses and issued ops against queued expectations.
module tb_instr_fetch_decode;

  localparam int           ADDR_W = 8;
  localparam logic [7:0]   RPC    = 8'hFF;

  typedef struct {
    logic [3:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] imm;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_op;
  logic [2:0]        issue_reg_dst;
  logic [2:0]        issue_reg_src;
  logic [7:0]        issue_imm;
  logic              halted;
  logic              illegal;

  instr_fetch_decode #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_reg_dst (issue_reg_dst),
    .issue_reg_src (issue_reg_src),
    .issue_imm     (issue_imm),
    .halted        (halted),
    .illegal       (illegal)
  );

  int          total;
  int          bad;
  int          cycle;
  logic [15:0] mem [256];
  logic        ack_en;
  logic        force_ack;
  logic [15:0] force_data;

  logic [7:0]  exp_addr [$];
  exp_t        exp_issue [$];
  int          fetch_cyc [$];
  int          acc_cyc [$];
  int          stall_cnt;
  logic        halted_seen;
  int          halt_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Zero-wait memory: acks in the same cycle the request is seen.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      imem_ack   = (ack_en && imem_req) || force_ack;
      imem_rdata = force_ack ? force_data : mem[imem_addr];
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (imem_req && imem_ack) begin
          if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_unexpected: got addr %0h required no fetch", imem_addr);
          end else begin
            check("fetch_addr", imem_addr, exp_addr.pop_front());
          end
          fetch_cyc.push_back(cycle);
        end
        if (issue_valid) begin
          check("req_while_valid", imem_req, 0);
          if (exp_issue.size() == 0) begin
            total++;
            bad++;
            $display("FAIL issue_unexpected: got op %0h required no issue", issue_op);
          end else begin
            e = exp_issue[0];
            check("issue_op", issue_op, e.op);
            check("issue_dst", issue_reg_dst, e.dst);
            check("issue_src", issue_reg_src, e.src);
            check("issue_imm", issue_imm, e.imm);
            if (issue_ready) begin
              void'(exp_issue.pop_front());
              acc_cyc.push_back(cycle);
            end else begin
              stall_cnt++;
            end
          end
        end
        if (halted) begin
          check("req_after_halt", imem_req, 0);
          check("valid_after_halt", issue_valid, 0);
          if (!halted_seen) begin
            halted_seen = 1'b1;
            halt_cyc    = cycle;
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_valid"}, issue_valid, 0);
    check({tag, "_fields"}, {issue_op, issue_reg_dst, issue_reg_src, issue_imm}, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_illegal"}, illegal, 0);
  endtask

  task automatic reset_begin();
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    exp_addr.delete();
    exp_issue.delete();
    fetch_cyc.delete();
    acc_cyc.delete();
    stall_cnt   = 0;
    halted_seen = 1'b0;
    halt_cyc    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic reset_end();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, RPC);
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("halt_reached", halted, 1);
    repeat (3) @(negedge clk);
    #2;
    check("queues_drained", {exp_addr.size() == 0, exp_issue.size() == 0}, 2'b11);
  endtask

  initial begin
    rst_n       = 1'b1;
    issue_ready = 1'b1;
    ack_en      = 1'b1;
    force_ack   = 1'b0;
    force_data  = 16'h0000;
    total       = 0;
    bad         = 0;
    stall_cnt   = 0;
    halted_seen = 1'b0;
    halt_cyc    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    #2;

    // MOV at 0xFF, LDI at 0x00 after the wrap, then HLT; ready held high.
    reset_begin();
    mem[8'hFF] = 16'h1A40;
    mem[8'h00] = 16'h7E2A;
    exp_addr.push_back(8'hFF);
    exp_addr.push_back(8'h00);
    exp_addr.push_back(8'h01);
    exp_issue.push_back('{4'h1, 3'd5, 3'd1, 8'h00});
    exp_issue.push_back('{4'h7, 3'd7, 3'd0, 8'h2A});
    reset_end();
    wait_halted(40);
    check("t1_illegal", illegal, 0);
    check("t1_counts", {fetch_cyc.size(), acc_cyc.size()}, {32'd3, 32'd2});
    if (fetch_cyc.size() == 3 && acc_cyc.size() == 2) begin
      check("t1_issue_lat", acc_cyc[0] - fetch_cyc[0], 1);
      check("t1_refetch_lat", fetch_cyc[1] - acc_cyc[0], 1);
      check("t1_op_period", acc_cyc[1] - acc_cyc[0], 2);
      check("t1_halt_lat", halt_cyc - fetch_cyc[2], 1);
    end

    // Backpressure: ready low for five valid cycles on a MOV.
    reset_begin();
    issue_ready = 1'b0;
    mem[8'hFF] = 16'h1A40;
    exp_addr.push_back(8'hFF);
    exp_addr.push_back(8'h00);
    exp_issue.push_back('{4'h1, 3'd5, 3'd1, 8'h00});
    reset_end();
    for (int n = 0; n < 20 && !issue_valid; n++) @(negedge clk);
    check("t2_valid_seen", issue_valid, 1);
    repeat (4) @(negedge clk);
    @(negedge clk);
    issue_ready = 1'b1;
    wait_halted(40);
    check("t2_stall_cycles", stall_cnt, 5);
    check("t2_accepts", acc_cyc.size(), 1);

    // NOP wraps to 0x00, JMP to 0x10, ADD issued, then HLT at 0x11.
    reset_begin();
    mem[8'hFF] = 16'h0000;
    mem[8'h00] = 16'h8010;
    mem[8'h10] = 16'h2250;
    exp_addr.push_back(8'hFF);
    exp_addr.push_back(8'h00);
    exp_addr.push_back(8'h10);
    exp_addr.push_back(8'h11);
    exp_issue.push_back('{4'h2, 3'd1, 3'd1, 8'h00});
    reset_end();
    wait_halted(40);
    check("t3_fetches", fetch_cyc.size(), 4);
    if (fetch_cyc.size() == 4) begin
      check("t3_nop_gap", fetch_cyc[1] - fetch_cyc[0], 1);
      check("t3_jmp_gap", fetch_cyc[2] - fetch_cyc[1], 1);
    end
    check("t3_illegal", illegal, 0);

    // Undefined opcode halts with illegal set.
    reset_begin();
    mem[8'hFF] = 16'h9000;
    exp_addr.push_back(8'hFF);
    reset_end();
    wait_halted(20);
    check("t4_illegal", illegal, 1);
    if (fetch_cyc.size() == 1) check("t4_halt_lat", halt_cyc - fetch_cyc[0], 1);

    // Reset with a request outstanding; a late ack during reset is ignored.
    reset_begin();
    ack_en = 1'b0;
    mem[8'hFF] = 16'h1A40;
    reset_end();
    repeat (2) @(negedge clk);
    #1;
    check("t5_req_held", imem_req, 1);
    check("t5_addr_held", imem_addr, RPC);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_midrst");
    repeat (3) @(posedge clk);
    #1;
    force_data = 16'h1A40;
    force_ack  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("t5_lateack");
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    reset_begin();
    ack_en = 1'b1;
    mem[8'hFF] = 16'h1A40;
    exp_addr.push_back(8'hFF);
    exp_addr.push_back(8'h00);
    exp_issue.push_back('{4'h1, 3'd5, 3'd1, 8'h00});
    reset_end();
    wait_halted(40);
    check("t5_accepts", acc_cyc.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Front-end fetch/decode unit for the core. It requests 16-bit instruction words from instruction memory over a req/ack handshake and decodes opcode, register and immediate fields. It issues one decoded operation at a time to the execution ops (`op_mov` and siblings) over a valid/ready handshake. NOP, JMP and HLT are consumed internally.

## Interface
Parameters:
- `ADDR_W`, 8, PC / instruction-address width; legal range 1..8.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  ADDR_W  fetch address (current PC); stable while `imem_req`=1.
- `imem_ack`  in  1  memory response; `imem_rdata` valid in the same cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  16  instruction word.
- `issue_valid`  out  1  decoded op available.
- `issue_ready`  in  1  execution stage accepts the op.
- `issue_op`  out  4  opcode (bits [15:12]).
- `issue_reg_dst`  out  3  destination register (bits [11:9]).
- `issue_reg_src`  out  3  source register (bits [8:6]); 0 for LDI.
- `issue_imm`  out  8  immediate (bits [7:0]) for LDI; 0 otherwise.
- `halted`  out  1  sticky; HLT or illegal executed.
- `illegal`  out  1  sticky; halt caused by an undefined opcode.

## Operation
- Opcodes:
  - Issued: 0x1 MOV, 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR, 0x7 LDI.
  - Internal: 0x0 NOP, 0x8 JMP, 0xF HLT.
  - Illegal: 0x9–0xE.
- LDI: `dst`=[11:9], `imm`=[7:0]; bit 8 is ignored.
- Reg-reg ops (0x1–0x6): `imm` forced to 0.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`, decode `imem_rdata`:
    - Issued op: register the fields, go to ISSUE.
    - NOP: PC←PC+1, stay in FETCH.
    - JMP: PC←`imem_rdata`[ADDR_W-1:0], stay in FETCH.
    - HLT: go to HALT, `halted`←1.
    - Illegal: go to HALT, `halted`←1, `illegal`←1.
  - ISSUE: `issue_valid`=1, fields held stable. On `issue_ready`: PC←PC+1, go to FETCH.
  - HALT: `imem_req`=0, `issue_valid`=0. Exit only via reset.
- PC increment wraps modulo 2^ADDR_W (e.g. 0xFF→0x00 at ADDR_W=8).
- `imem_rdata` is never sampled without `imem_ack`. `issue_ready` is ignored outside ISSUE.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `issue_valid`=0; `issue_op`/`issue_reg_dst`/`issue_reg_src`/`issue_imm`=0.
  - `halted`=0, `illegal`=0. State=FETCH.
- First cycle after `rst_n` deasserts: `imem_req`=1 with `imem_addr`=RESET_PC.
- Ack in cycle N for an issued op → `issue_valid`=1 in N+1; `imem_req`=0 from N+1.
- Accept (`issue_valid`&`issue_ready`) in cycle M → `issue_valid`=0 and `imem_req`=1 with PC+1 in M+1.
- Throughput with zero-wait memory and ready always 1: one issued op every 2 cycles.
- NOP/JMP ack in cycle N → new `imem_addr` in N+1 with `imem_req` still 1. Back-to-back NOPs fetch one address per cycle.
- Outputs are registered; no combinational path from `issue_ready` or `imem_ack` to any output.
- `issue_valid` never drops and fields never change until accepted (backpressure of any length).
- HLT/illegal ack in cycle N → `halted`=1 (and `illegal` if applicable) in N+1, `imem_req`=0 in N+1.
- Reset mid-operation: asynchronous clear to the reset values, including an outstanding `imem_req` or pending `issue_valid`. A late `imem_ack` is ignored.

## Test plan
- Zero-wait memory with {0x1A40 MOV r5←r1, 0x7E2A LDI r7←0x2A}, ready=1 → issues (op1,dst5,src1,imm0) then (op7,dst7,src0,imm0x2A); fetch addresses 0,1; 2 cycles per op.
- Backpressure: ready=0 for 5 cycles on a MOV → `issue_valid` and fields stable 5 cycles; no `imem_req` until accept; next fetch address 1.
- NOP at 0, JMP 0x8010 at 1, ADD 0x2250 at 0x10 → addresses 0,1,0x10 on consecutive cycles; only ADD issued (dst1,src1).
- Wrap: RESET_PC=0xFF, MOV at 0xFF → after accept, `imem_addr`=0x00.
- HLT 0xF000 → `halted`=1 next cycle, `illegal`=0, no further requests. Opcode 0x9000 → `halted`=1 and `illegal`=1.
- Assert `rst_n`=0 with `imem_req` outstanding, then ack 3 cycles late → all outputs at reset values, ack ignored, restart fetch at RESET_PC.
